// File: rtl/perf_pkg.sv
// Shared encodings for the performance counter controller.
// Command opcodes, FSM states and default sizing.
package perf_pkg;

    localparam int DEF_WIDTH  = 32;
    localparam int DEF_NUM_EV = 4;

    typedef enum logic [1:0] {
        OP_START = 2'd0,
        OP_STOP  = 2'd1,
        OP_CLEAR = 2'd2,
        OP_SNAP  = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_CLR  = 2'd2
    } state_e;

endpackage

// File: rtl/perf_counter_slice.sv
// One event counter with its sticky overflow flag and shadow copy.
// Shadow captures the pre-increment value on snap.
module perf_counter_slice #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    input  logic             snap,
    output logic             wrap,
    output logic             ovf,
    output logic [WIDTH-1:0] shadow
);

    logic [WIDTH-1:0] count;

    assign wrap = inc && (&count);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= '0;
            ovf    <= 1'b0;
            shadow <= '0;
        end else begin
            if (clr) begin
                count <= '0;
                ovf   <= 1'b0;
            end else if (inc) begin
                count <= count + 1'b1;
                if (wrap) ovf <= 1'b1;
            end
            if (snap) shadow <= count;
        end
    end

endmodule

// File: rtl/perf_count_ctrl.sv
// Performance counter controller: start/stop/clear/snapshot FSM
// driving NUM_EV counter slices with a readable shadow bank.
module perf_count_ctrl
    import perf_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int NUM_EV = DEF_NUM_EV,
    localparam int IW    = $clog2(NUM_EV)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_EV-1:0] ev,
    input  logic              halt,
    input  logic              stop_on_ovf,
    input  logic              cmd_valid,
    input  logic [1:0]        cmd_op,
    output logic              cmd_ready,
    input  logic [IW-1:0]     rd_sel,
    output logic [WIDTH-1:0]  rd_data,
    output logic              running,
    output logic [NUM_EV-1:0] ovf,
    output logic              busy
);

    state_e            state, state_nxt;
    logic [IW-1:0]     idx;
    logic              acc;
    logic              snap;
    logic [NUM_EV-1:0] inc, clr, wrap;
    logic [WIDTH-1:0]  shadow [NUM_EV];

    assign acc  = cmd_valid && cmd_ready;
    assign snap = acc && (cmd_op == OP_SNAP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (acc && cmd_op == OP_START)
                    state_nxt = S_RUN;
                else if (acc && cmd_op == OP_CLEAR)
                    state_nxt = S_CLR;
            end
            S_RUN: begin
                if (acc && cmd_op == OP_CLEAR)
                    state_nxt = S_CLR;
                else if (halt || (acc && cmd_op == OP_STOP)
                         || (stop_on_ovf && |wrap))
                    state_nxt = S_IDLE;
            end
            S_CLR: begin
                if (idx == IW'(NUM_EV - 1))
                    state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (state != S_CLR);
        running   = (state == S_RUN);
        busy      = (state == S_CLR);
    end

    // Clear walks one slice per cycle; idx wraps back to 0 on exit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)             idx <= '0;
        else if (state == S_CLR) idx <= idx + 1'b1;
        else                    idx <= '0;
    end

    for (genvar i = 0; i < NUM_EV; i++) begin : g_slice
        assign inc[i] = running && ev[i];
        assign clr[i] = busy && (idx == IW'(i));

        perf_counter_slice #(
            .WIDTH(WIDTH)
        ) u_slice (
            .clk   (clk),
            .rst_n (rst_n),
            .inc   (inc[i]),
            .clr   (clr[i]),
            .snap  (snap),
            .wrap  (wrap[i]),
            .ovf   (ovf[i]),
            .shadow(shadow[i])
        );
    end

    assign rd_data = shadow[rd_sel];

endmodule

// File: tb/tb_perf_count_ctrl.sv
// Directed bench for perf_count_ctrl (WIDTH=8, NUM_EV=4).
// Counters are observed through SNAP and the shadow read port.
module tb_perf_count_ctrl;
    import perf_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] ev = '0;
    logic       halt = 1'b0;
    logic       stop_on_ovf = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_op = 2'd0;
    logic       cmd_ready;
    logic [1:0] rd_sel = '0;
    logic [7:0] rd_data;
    logic       running;
    logic [3:0] ovf;
    logic       busy;

    int checks = 0;
    int failures = 0;

    perf_count_ctrl #(.WIDTH(8), .NUM_EV(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ev         (ev),
        .halt       (halt),
        .stop_on_ovf(stop_on_ovf),
        .cmd_valid  (cmd_valid),
        .cmd_op     (cmd_op),
        .cmd_ready  (cmd_ready),
        .rd_sel     (rd_sel),
        .rd_data    (rd_data),
        .running    (running),
        .ovf        (ovf),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Apply inputs for one edge, observe 1ns after it, then idle inputs.
    task automatic tick(input logic [3:0] e, input logic v,
                        input logic [1:0] op, input logic h);
        ev = e; cmd_valid = v; cmd_op = op; halt = h;
        @(posedge clk);
        #1;
        ev = '0; cmd_valid = 1'b0; cmd_op = 2'd0; halt = 1'b0;
    endtask

    task automatic cmd(input logic [1:0] op);
        tick(4'b0000, 1'b1, op, 1'b0);
    endtask

    task automatic rd(input logic [1:0] s, output logic [7:0] d);
        rd_sel = s;
        #1;
        d = rd_data;
    endtask

    task automatic chk_rd(input string tag, input logic [1:0] s,
                          input logic [7:0] exp);
        logic [7:0] d;
        rd(s, d);
        chk(tag, {24'd0, d}, {24'd0, exp});
    endtask

    initial begin
        #2;
        chk("rst_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_running", {31'd0, running}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_ovf", {28'd0, ovf}, 32'd0);
        chk_rd("rst_rd", 2'd0, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic count of a 0101 pattern
        cmd(OP_START);
        chk("start_run", {31'd0, running}, 32'd1);
        for (int i = 0; i < 10; i++) tick(4'b0101, 1'b0, 2'd0, 1'b0);
        cmd(OP_STOP);
        chk("stop_idle", {31'd0, running}, 32'd0);
        cmd(OP_SNAP);
        chk_rd("p_rd0", 2'd0, 8'd10);
        chk_rd("p_rd1", 2'd1, 8'd0);
        chk_rd("p_rd2", 2'd2, 8'd10);
        chk_rd("p_rd3", 2'd3, 8'd0);

        // Clear from IDLE
        cmd(OP_CLEAR);
        chk("iclr_busy", {31'd0, busy}, 32'd1);
        for (int i = 0; i < 4; i++) tick(4'b0000, 1'b0, 2'd0, 1'b0);
        chk("iclr_done", {31'd0, busy}, 32'd0);

        // Wrap with stop_on_ovf
        stop_on_ovf = 1'b1;
        cmd(OP_START);
        for (int i = 0; i < 255; i++) tick(4'b0001, 1'b0, 2'd0, 1'b0);
        chk("pre_wrap_run", {31'd0, running}, 32'd1);
        chk("pre_wrap_ovf", {28'd0, ovf}, 32'd0);
        tick(4'b0001, 1'b0, 2'd0, 1'b0);
        chk("wrap_ovf", {28'd0, ovf}, 32'h1);
        chk("wrap_stop", {31'd0, running}, 32'd0);
        tick(4'b0001, 1'b0, 2'd0, 1'b0);
        cmd(OP_SNAP);
        chk_rd("wrap_cnt", 2'd0, 8'd0);
        stop_on_ovf = 1'b0;

        // CLEAR while running; START during CLR is refused
        cmd(OP_START);
        tick(4'b1111, 1'b0, 2'd0, 1'b0);
        tick(4'b0001, 1'b1, OP_CLEAR, 1'b0);
        chk("clr_busy", {31'd0, busy}, 32'd1);
        chk("clr_ready", {31'd0, cmd_ready}, 32'd0);
        chk("clr_ovf_held", {28'd0, ovf}, 32'h1);
        tick(4'b1111, 1'b1, OP_START, 1'b0);
        chk("clr_ovf0", {28'd0, ovf}, 32'h0);
        chk("clr_busy2", {31'd0, busy}, 32'd1);
        tick(4'b1111, 1'b1, OP_START, 1'b0);
        tick(4'b1111, 1'b1, OP_START, 1'b0);
        chk("clr_busy4", {31'd0, busy}, 32'd1);
        tick(4'b1111, 1'b1, OP_START, 1'b0);
        chk("clr_end_busy", {31'd0, busy}, 32'd0);
        chk("clr_end_run", {31'd0, running}, 32'd0);
        chk("clr_end_ready", {31'd0, cmd_ready}, 32'd1);
        cmd(OP_SNAP);
        chk_rd("clr_rd0", 2'd0, 8'd0);
        chk_rd("clr_rd1", 2'd1, 8'd0);
        chk_rd("clr_rd3", 2'd3, 8'd0);

        // halt beats START; event in halt cycle counted
        cmd(OP_START);
        for (int i = 0; i < 5; i++) tick(4'b0010, 1'b0, 2'd0, 1'b0);
        tick(4'b0010, 1'b1, OP_START, 1'b1);
        chk("halt_stop", {31'd0, running}, 32'd0);
        tick(4'b0010, 1'b0, 2'd0, 1'b0);
        chk("halt_stay", {31'd0, running}, 32'd0);
        cmd(OP_SNAP);
        chk_rd("halt_cnt", 2'd1, 8'd6);
        cmd(OP_START);
        chk("halt_resume", {31'd0, running}, 32'd1);

        // SNAP excludes same-cycle event; shadow survives CLEAR
        for (int i = 0; i < 7; i++) tick(4'b0001, 1'b0, 2'd0, 1'b0);
        tick(4'b0001, 1'b1, OP_SNAP, 1'b0);
        chk_rd("snap_pre", 2'd0, 8'd7);
        tick(4'b0001, 1'b1, OP_STOP, 1'b0);
        cmd(OP_SNAP);
        chk_rd("snap_post", 2'd0, 8'd9);
        cmd(OP_CLEAR);
        for (int i = 0; i < 4; i++) tick(4'b0000, 1'b0, 2'd0, 1'b0);
        chk_rd("shadow_keep", 2'd0, 8'd9);
        chk_rd("shadow_keep1", 2'd1, 8'd6);

        // Reset during CLR cycle 2
        cmd(OP_START);
        for (int i = 0; i < 3; i++) tick(4'b1111, 1'b0, 2'd0, 1'b0);
        cmd(OP_SNAP);
        chk_rd("mr_pre", 2'd3, 8'd3);
        cmd(OP_CLEAR);
        tick(4'b0000, 1'b0, 2'd0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("mr_busy", {31'd0, busy}, 32'd0);
        chk("mr_ready", {31'd0, cmd_ready}, 32'd1);
        chk("mr_running", {31'd0, running}, 32'd0);
        chk_rd("mr_rd", 2'd3, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mr_idle_busy", {31'd0, busy}, 32'd0);
        chk("mr_idle_run", {31'd0, running}, 32'd0);
        cmd(OP_SNAP);
        chk_rd("mr_cnt2", 2'd2, 8'd0);
        chk_rd("mr_cnt3", 2'd3, 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/perf_count_ctrl.md
PERF_COUNT_CTRL -- requirements
Module: perf_count_ctrl

Interface
REQ-001 Parameter WIDTH, default 32: bit width of each event counter and of rd_data.
REQ-002 Parameter NUM_EV, default 4: number of event inputs and counters, power of two, 2..16.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 ev  input  NUM_EV  per-cycle event pulses; bit i increments counter i.
REQ-006 halt  input  1  CPU halt indication; auto-stops counting.
REQ-007 stop_on_ovf  input  1  quasi-static; 1 = any overflow stops counting.
REQ-008 cmd_valid  input  1  command request.
REQ-009 cmd_op  input  2  command: 0 START, 1 STOP, 2 CLEAR, 3 SNAP.
REQ-010 cmd_ready  output  1  command may be accepted this cycle.
REQ-011 rd_sel  input  log2(NUM_EV)  shadow register select.
REQ-012 rd_data  output  WIDTH  shadow[rd_sel], combinational.
REQ-013 running  output  1  high only in state RUN.
REQ-014 ovf  output  NUM_EV  sticky per-counter overflow flags.
REQ-015 busy  output  1  high only in state CLR.

Function
REQ-016 Command accepted on a rising edge where cmd_valid && cmd_ready; cmd_ready SHALL be 1 in IDLE and RUN, 0 in CLR.
REQ-017 FSM states SHALL be IDLE, RUN, CLR.
REQ-018 IDLE: START -> RUN; CLEAR -> CLR; STOP -> no effect; SNAP -> no state change.
REQ-019 RUN: STOP -> IDLE; CLEAR -> CLR; START -> no effect; SNAP -> no state change.
REQ-020 RUN with halt=1 SHALL go to IDLE at the next edge; halt has priority over a simultaneous START (no effect) and equals STOP.
REQ-021 Counter i SHALL increment by 1 on an edge only while state is RUN and ev[i]=1; events in the cycle STOP/halt is accepted are counted, events in the cycle START is accepted are not.
REQ-022 Counter increment wraps modulo 2^WIDTH; all-ones + 1 -> 0 and sets ovf[i] on the same edge.
REQ-023 If stop_on_ovf=1 and any counter wraps in RUN, FSM SHALL go to IDLE on that edge; the wrapping increment itself is applied.
REQ-024 CLR SHALL last exactly NUM_EV cycles, clearing counter k and ovf[k] in its k-th cycle (k=0..NUM_EV-1) via an internal index counter, then go to IDLE; no counting occurs in CLR.
REQ-025 SNAP SHALL copy every counter to its shadow register on the acceptance edge, capturing pre-increment values (events in that cycle excluded from the snapshot, included in counters).
REQ-026 Shadow registers are unaffected by CLEAR; only SNAP or reset changes them.
REQ-027 ovf bits are sticky; cleared only by CLR of that index or reset.
REQ-028 rd_data SHALL reflect rd_sel in the same cycle with no register stage.

Reset
REQ-029 rst_n=0 SHALL immediately force state IDLE, all counters, shadows, ovf and clear index to 0.
REQ-030 Outputs during/after reset: cmd_ready=1, running=0, busy=0, ovf=0, rd_data=0.
REQ-031 Reset asserted mid-CLR SHALL abort the sequence; after release FSM is IDLE with all counters 0.

Structure
REQ-032 Package perf_pkg SHALL hold cmd_op encodings (OP_START, OP_STOP, OP_CLEAR, OP_SNAP), FSM state encoding and default WIDTH/NUM_EV constants.
REQ-033 One sub-module perf_counter_slice (one counter, its ovf flag, its shadow register; inputs inc, clr, snap) SHALL be instantiated NUM_EV times.

Verification
REQ-034 START, ev=4'b0101 for 10 cycles, STOP, SNAP -> rd_sel 0 and 2 read 10, rd_sel 1 and 3 read 0, running=0.
REQ-035 WIDTH=8, preload counter 0 to 255 via 255 events, stop_on_ovf=1, one more ev[0] -> counter 0 = 0, ovf=4'b0001, state IDLE on that edge.
REQ-036 In RUN, CLEAR -> busy=1 and cmd_ready=0 for exactly 4 cycles, counters 0..3 cleared in order, then IDLE with ovf=0; ev pulses during CLR not counted.
REQ-037 In RUN with counter 1 = 5, halt=1 and ev[1]=1 same cycle -> counter 1 = 6, running=0 next cycle, later START required to resume.
REQ-038 SNAP with ev[0]=1 same cycle, counter 0 = 7 -> shadow 0 = 7, counter 0 = 8; CLEAR afterwards leaves shadow 0 = 7.
REQ-039 Assert rst_n=0 during CLR cycle 2 with counters nonzero -> all outputs at reset values immediately, FSM IDLE after release.
